// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared defaults, index-width helper and requester index names
//   DEF_WIDTH   : default operand/sum width
//   DEF_NUM_REQ : default number of requesters
//   DEF_ID_W    : requester index width derived from DEF_NUM_REQ
//   req_idx_e   : symbolic requester indices
package adder_arb_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_NUM_REQ = 4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    localparam int DEF_ID_W = clog2(DEF_NUM_REQ);

    typedef enum logic [2:0] {
        REQ_PC4    = 3'd0,
        REQ_BRANCH = 3'd1,
        REQ_AGU    = 3'd2,
        REQ_SPARE  = 3'd3
    } req_idx_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant starting the search at ptr
//   req      : per-requester request lines
//   ptr      : index searched first, wrapping modulo N
//   enable   : when low no grant is issued
//   grant    : one-hot grant (all zero when nothing granted)
//   grant_id : encoded index of the granted requester
module rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int N    = DEF_NUM_REQ,
    parameter int ID_W = clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    input  logic            enable,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id
);

    logic            found;
    logic [ID_W-1:0] idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = '0;
        for (int k = 0; k < N; k++) begin
            idx = ID_W'((int'(ptr) + k) % N);
            if (enable && !found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = idx;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: one shared adder, round-robin among requesters, single result register
//   clk, rst_n       : clock, asynchronous active-low reset
//   req_valid/ready  : per-requester handshake (ready is one-hot or zero)
//   req_a, req_b     : packed operands, slice i = [i*WIDTH +: WIDTH]
//   out_valid/ready  : result handshake
//   out_sum/carry    : registered A+B and its carry out
//   out_id           : index of the requester that produced out_sum
//   out_ovf          : signed overflow, only when ADDER_ARB_OVF_EN is defined
module adder_share_arbiter
    import adder_arb_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_sum,
    output logic                     out_carry,
    output logic [ID_W-1:0]          out_id
`ifdef ADDER_ARB_OVF_EN
    ,
    output logic                     out_ovf
`endif
);

    logic              can_accept;
    logic              accept;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   gid;
    logic [WIDTH-1:0]  a_sel;
    logic [WIDTH-1:0]  b_sel;
    logic [WIDTH:0]    sum_full;

    // rst_n gates the grant so no requester sees ready while reset is held
    assign can_accept = (!out_valid || out_ready) && rst_n;

    rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req      (req_valid),
        .ptr      (ptr),
        .enable   (can_accept),
        .grant    (req_ready),
        .grant_id (gid)
    );

    // a grant is only issued to a valid requester, so any ready bit is a handshake
    assign accept   = |req_ready;
    assign a_sel    = req_a[int'(gid)*WIDTH +: WIDTH];
    assign b_sel    = req_b[int'(gid)*WIDTH +: WIDTH];
    assign sum_full = {1'b0, a_sel} + {1'b0, b_sel};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_carry <= 1'b0;
            out_id    <= '0;
            ptr       <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_sum   <= sum_full[WIDTH-1:0];
            out_carry <= sum_full[WIDTH];
            out_id    <= gid;
            ptr       <= (int'(gid) == NUM_REQ - 1) ? '0 : gid + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ADDER_ARB_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out_ovf <= 1'b0;
        else if (accept)
            out_ovf <= (a_sel[WIDTH-1] == b_sel[WIDTH-1]) && (sum_full[WIDTH-1] != a_sel[WIDTH-1]);
    end
`endif

endmodule
